// File: rtl/jtopl_pkg.sv
// rtl/jtopl_pkg.sv - shared constants and multiplier table for the jtopl phase generator
package jtopl_pkg;

  localparam int NSLOT    = 18;
  localparam int PG_DEPTH = 3;
  localparam int PHASE_W  = 19;

  // Returns twice the effective frequency multiplier, so the 0.5x code stays integral
  function automatic logic [4:0] mul_x2(input logic [3:0] mul);
    logic [4:0] x2;
    case (mul)
      4'd0:         x2 = 5'd1;
      4'd11:        x2 = 5'd20;
      4'd12, 4'd13: x2 = 5'd24;
      4'd14, 4'd15: x2 = 5'd30;
      default:      x2 = {mul, 1'b0};
    endcase
    return x2;
  endfunction

endpackage

// File: rtl/jtopl_pg_pm.sv
// rtl/jtopl_pg_pm.sv - vibrato pitch offset from the top F-number bits and the LFO step
module jtopl_pg_pm (
  input  logic [2:0]        fnum_hi,
  input  logic [2:0]        vib_cnt,
  input  logic              vib_dep,
  input  logic              vib_en,
  output logic signed [3:0] pm
);

  logic [2:0] full;
  logic [2:0] half;

  always_comb begin
    full = vib_dep ? fnum_hi : (fnum_hi >> 1);
    half = full >> 1;
    pm   = 4'sd0;
    if (vib_en) begin
      // Triangle over eight steps: rise to +full, back through zero, down to -full
      case (vib_cnt)
        3'd1, 3'd3: pm = $signed({1'b0, half});
        3'd2:       pm = $signed({1'b0, full});
        3'd5, 3'd7: pm = -$signed({1'b0, half});
        3'd6:       pm = -$signed({1'b0, full});
        default:    pm = 4'sd0;
      endcase
    end
  end

endmodule

// File: rtl/jtopl_pg_sched.sv
// rtl/jtopl_pg_sched.sv - three-stage time-multiplexed phase generator with circular phase store
module jtopl_pg_sched
  import jtopl_pkg::*;
#(
  parameter int NSLOT = jtopl_pkg::NSLOT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [9:0] fnum_I,
  input  logic [2:0] block_I,
  input  logic [3:0] mul_I,
  input  logic       vib_en_I,
  input  logic       keyon_I,
  input  logic [2:0] vib_cnt,
  input  logic       vib_dep,
  output logic [4:0] slot,
  output logic       zero,
  output logic [4:0] out_slot,
  output logic [9:0] phase_out
);

  logic signed [3:0]   pm_I;

  logic [9:0]          fnum_II;
  logic [2:0]          block_II;
  logic [3:0]          mul_II;
  logic                keyon_II;
  logic signed [3:0]   pm_II;

  logic [16:0]         phinc_III;
  logic [4:0]          x2_III;
  logic                keyon_III;

  logic [16:0]         freq_II;
  logic [23:0]         phinc_wide;
  logic [16:0]         phinc_II;
  logic [21:0]         prod_III;
  logic [PHASE_W-1:0]  inc_III;
  logic [PHASE_W-1:0]  phase_old;
  logic [PHASE_W-1:0]  phase_new;

  logic [PHASE_W-1:0]  phase_sr [NSLOT];
  logic [4:0]          slot_dly [PG_DEPTH];

  jtopl_pg_pm u_pm (
    .fnum_hi (fnum_I[9:7]),
    .vib_cnt (vib_cnt),
    .vib_dep (vib_dep),
    .vib_en  (vib_en_I),
    .pm      (pm_I)
  );

  assign zero     = (slot == 5'd0);
  assign out_slot = slot_dly[PG_DEPTH-1];

  // Stage II: fnum never underflows because pm is zero whenever fnum[9:7] is zero
  always_comb begin
    freq_II    = {7'd0, fnum_II} + {{13{pm_II[3]}}, pm_II};
    phinc_wide = {7'd0, freq_II} << block_II;
    phinc_II   = 17'(phinc_wide >> 1);
  end

  // Stage III: the oldest store entry is the previous phase of the slot now in stage III
  always_comb begin
    prod_III  = {5'd0, phinc_III} * {17'd0, x2_III};
    inc_III   = PHASE_W'(prod_III >> 1);
    phase_old = phase_sr[NSLOT-1];
    phase_new = keyon_III ? '0 : phase_old + inc_III;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= 5'd0;
      fnum_II   <= '0;
      block_II  <= '0;
      mul_II    <= '0;
      keyon_II  <= 1'b0;
      pm_II     <= '0;
      phinc_III <= '0;
      x2_III    <= '0;
      keyon_III <= 1'b0;
      phase_out <= '0;
      for (int i = 0; i < NSLOT; i++) phase_sr[i] <= '0;
      for (int i = 0; i < PG_DEPTH; i++) slot_dly[i] <= '0;
    end else if (cen) begin
      slot      <= (slot == 5'(NSLOT-1)) ? 5'd0 : slot + 5'd1;

      fnum_II   <= fnum_I;
      block_II  <= block_I;
      mul_II    <= mul_I;
      keyon_II  <= keyon_I;
      pm_II     <= pm_I;

      phinc_III <= phinc_II;
      x2_III    <= mul_x2(mul_II);
      keyon_III <= keyon_II;

      phase_sr[0] <= phase_new;
      for (int i = 1; i < NSLOT; i++) phase_sr[i] <= phase_sr[i-1];
      phase_out <= phase_new[PHASE_W-1:PHASE_W-10];

      slot_dly[0] <= slot;
      for (int i = 1; i < PG_DEPTH; i++) slot_dly[i] <= slot_dly[i-1];
    end
  end

endmodule

// File: tb/tb_jtopl_pg_sched.sv
// tb/tb_jtopl_pg_sched.sv - directed bench for the phase generator scheduler
module tb_jtopl_pg_sched;

  localparam int NSLOT = 18;

  logic       clk;
  logic       rst;
  logic       cen;
  logic [9:0] fnum_I;
  logic [2:0] block_I;
  logic [3:0] mul_I;
  logic       vib_en_I;
  logic       keyon_I;
  logic [2:0] vib_cnt;
  logic       vib_dep;
  logic [4:0] slot;
  logic       zero;
  logic [4:0] out_slot;
  logic [9:0] phase_out;

  jtopl_pg_sched #(.NSLOT(NSLOT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .fnum_I    (fnum_I),
    .block_I   (block_I),
    .mul_I     (mul_I),
    .vib_en_I  (vib_en_I),
    .keyon_I   (keyon_I),
    .vib_cnt   (vib_cnt),
    .vib_dep   (vib_dep),
    .slot      (slot),
    .zero      (zero),
    .out_slot  (out_slot),
    .phase_out (phase_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] cfg_fnum  [NSLOT];
  logic [2:0] cfg_block [NSLOT];
  logic [3:0] cfg_mul   [NSLOT];
  logic       cfg_vib   [NSLOT];
  logic       cfg_keyon [NSLOT];
  int         obs       [NSLOT];

  int n_checks = 0;
  int n_errors = 0;
  int tb_slot;
  int hist0, hist1, hist2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One enabled clock: drive the slot's config, then track where its result will appear
  task automatic step();
    fnum_I   = cfg_fnum[tb_slot];
    block_I  = cfg_block[tb_slot];
    mul_I    = cfg_mul[tb_slot];
    vib_en_I = cfg_vib[tb_slot];
    keyon_I  = cfg_keyon[tb_slot];
    cen      = 1'b1;
    @(posedge clk);
    #1;
    cen   = 1'b0;
    hist2 = hist1;
    hist1 = hist0;
    hist0 = tb_slot;
    tb_slot = (tb_slot == NSLOT-1) ? 0 : tb_slot + 1;
    chk("slot", 32'(slot), 32'(tb_slot));
    chk("zero", 32'(zero), 32'(tb_slot == 0));
    chk("out_slot", 32'(out_slot), 32'(hist2));
    obs[hist2] = 32'(phase_out);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cen      = 1'($urandom_range(0, 1));
      fnum_I   = 10'($urandom);
      keyon_I  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cen = 1'b0;
    tb_slot = 0;
    hist0 = 0; hist1 = 0; hist2 = 0;
    for (int i = 0; i < NSLOT; i++) obs[i] = -1;
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_out_slot", 32'(out_slot), 32'd0);
    chk("rst_phase", 32'(phase_out), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("idle_slot", 32'(slot), 32'd0);
    end
  endtask

  // pm vectors: slot 9 vib on, slot 10 same tone vib off, slot 11 fnum[9:7]=0
  int pm_cnt [4] = '{2, 6, 2, 4};
  int pm_dep [4] = '{1, 1, 0, 1};
  int pm_exp [4] = '{669, 642, 661, 656};

  initial begin
    rst = 1'b1; cen = 1'b0;
    fnum_I = '0; block_I = '0; mul_I = '0; vib_en_I = 1'b0; keyon_I = 1'b0;
    vib_cnt = '0; vib_dep = 1'b0;
    tb_slot = 0; hist0 = 0; hist1 = 0; hist2 = 0;
    for (int i = 0; i < NSLOT; i++) begin
      cfg_fnum[i] = '0; cfg_block[i] = '0; cfg_mul[i] = '0;
      cfg_vib[i] = 1'b0; cfg_keyon[i] = 1'b0; obs[i] = -1;
    end
    // 0x200 at block 4 gives phinc 4096; mul 0/1/15 -> inc 2048/4096/61440
    cfg_fnum[2] = 10'h200; cfg_block[2] = 3'd4; cfg_mul[2] = 4'd0;
    cfg_fnum[3] = 10'h200; cfg_block[3] = 3'd4; cfg_mul[3] = 4'd15;
    cfg_fnum[5] = 10'h200; cfg_block[5] = 3'd4; cfg_mul[5] = 4'd1;
    cfg_fnum[7] = 10'h200; cfg_block[7] = 3'd4; cfg_mul[7] = 4'd1;
    cfg_fnum[9]  = 10'h380; cfg_block[9]  = 3'd7; cfg_mul[9]  = 4'd15; cfg_vib[9]  = 1'b1;
    cfg_fnum[10] = 10'h380; cfg_block[10] = 3'd7; cfg_mul[10] = 4'd15; cfg_vib[10] = 1'b0;
    cfg_fnum[11] = 10'h07F; cfg_block[11] = 3'd7; cfg_mul[11] = 4'd1;  cfg_vib[11] = 1'b1;

    for (int v = 0; v < 4; v++) begin
      vib_cnt = 3'(pm_cnt[v]);
      vib_dep = 1'(pm_dep[v]);
      do_reset();
      steps(NSLOT + 2);
      chk("pm_vib_slot9", 32'(obs[9]), 32'(pm_exp[v]));
      chk("pm_off_slot10", 32'(obs[10]), 32'd656);
      chk("pm_low_slot11", 32'(obs[11]), 32'd15);
      chk("mul15_slot3", 32'(obs[3]), 32'd120);
    end

    vib_cnt = 3'd0; vib_dep = 1'b0;
    do_reset();
    steps(10 * NSLOT + 2);
    chk("f10_slot5", 32'(obs[5]), 32'd80);
    chk("f10_slot7", 32'(obs[7]), 32'd80);
    chk("f10_mul0_slot2", 32'(obs[2]), 32'd40);
    chk("f10_mul15_slot3", 32'(obs[3]), 32'd176);
    chk("f10_idle_slot0", 32'(obs[0]), 32'd0);

    cfg_keyon[7] = 1'b1;
    steps(NSLOT);
    cfg_keyon[7] = 1'b0;
    chk("keyon_slot7", 32'(obs[7]), 32'd0);
    chk("keyon_slot5", 32'(obs[5]), 32'd88);
    chk("keyon_slot2", 32'(obs[2]), 32'd44);
    chk("keyon_slot3", 32'(obs[3]), 32'd296);

    steps(116 * NSLOT);
    chk("f127_slot5", 32'(obs[5]), 32'd1016);
    chk("f127_slot7", 32'(obs[7]), 32'd928);
    steps(NSLOT);
    chk("f128_wrap_slot5", 32'(obs[5]), 32'd0);
    chk("f128_slot7", 32'(obs[7]), 32'd936);
    chk("f128_slot2", 32'(obs[2]), 32'd512);
    chk("f128_slot3", 32'(obs[3]), 32'd0);

    for (int i = 0; i < 40; i++) begin
      if (tb_slot == 11) break;
      step();
    end
    chk("reach_slot11", 32'(slot), 32'd11);
    do_reset();
    steps(NSLOT + 2);
    chk("mid_rst_slot5", 32'(obs[5]), 32'd8);
    chk("mid_rst_slot7", 32'(obs[7]), 32'd8);
    chk("mid_rst_slot2", 32'(obs[2]), 32'd4);
    chk("mid_rst_slot3", 32'(obs[3]), 32'd120);
    chk("mid_rst_slot0", 32'(obs[0]), 32'd0);

    for (int i = 0; i < 40; i++) begin
      step();
      if (hist2 == 3) break;
    end
    chk("hold_pre_out_slot", 32'(out_slot), 32'd3);
    chk("hold_pre_phase", 32'(phase_out), 32'd240);
    for (int i = 0; i < 6; i++) begin
      fnum_I  = 10'($urandom);
      mul_I   = 4'($urandom);
      keyon_I = 1'($urandom);
      @(posedge clk);
      #1;
      chk("hold_slot", 32'(slot), 32'(tb_slot));
      chk("hold_out_slot", 32'(out_slot), 32'd3);
      chk("hold_phase", 32'(phase_out), 32'd240);
    end
    steps(2);
    chk("post_hold_slot5", 32'(phase_out), 32'd16);
    chk("post_hold_out_slot", 32'(out_slot), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
